// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and port ids.
package dmem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_RESP  = ST_RESP
  } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester channels and the memory port around the arbiter.
//
// Handshake: a request transfers on a cycle where req_valid[i] && req_ready[i].
// A requester holds its fields stable while valid is high and ready is low; it
// may drop valid before acceptance. req_valid never depends on req_ready.
// resp_valid[i] is a one-cycle completion pulse; resp_rd is meaningful only then.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0]              req_we;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*DATA_WIDTH-1:0] req_wd;
  logic [2*BE_WIDTH-1:0]   req_be;
  logic [1:0]              resp_valid;
  logic [DATA_WIDTH-1:0]   resp_rd;
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wd;
  logic [BE_WIDTH-1:0]     mem_be;
  logic [DATA_WIDTH-1:0]   mem_rd;

  // Arbiter side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wd, req_be, mem_rd,
    output req_ready, resp_valid, resp_rd, mem_en, mem_we, mem_addr, mem_wd, mem_be
  );

  // Requesters plus memory side.
  modport master (
    output req_valid, req_we, req_addr, req_wd, req_be, mem_rd,
    input  req_ready, resp_valid, resp_rd, mem_en, mem_we, mem_addr, mem_wd, mem_be
  );
endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-input round-robin picker: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_id
);

  // Pick the winner; nothing is granted while disabled.
  always_comb begin
    grant    = 2'b00;
    grant_id = 1'b0;
    if (enable) begin
      case (valid)
        2'b01: begin
          grant    = 2'b01;
          grant_id = 1'b0;
        end
        2'b10: begin
          grant    = 2'b10;
          grant_id = 1'b1;
        end
        2'b11: begin
          grant_id = ~last_grant;
          grant    = last_grant ? 2'b01 : 2'b10;
        end
        default: begin
          grant    = 2'b00;
          grant_id = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous data RAM between the CPU port (0) and the
// debug/loader port (1). One access in flight; IDLE -> ISSUE -> RESP, with a new
// request accepted during RESP for one access every two cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_arbiter_if.slave        bus,
  output state_e               dbg_state
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  id_q, id_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [1:0]            resp_valid_q, resp_valid_d;

  logic                  arb_en;
  logic [1:0]            grant;
  logic                  grant_id;

  // Arbitration is live only in IDLE and RESP, and never during reset.
  assign arb_en = !rst && (state_q != S_ISSUE);

  rr_arbiter2 u_rr (
    .valid      (bus.req_valid),
    .last_grant (last_grant_q),
    .enable     (arb_en),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign bus.req_ready  = grant;
  assign bus.resp_valid = resp_valid_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wd     = wd_q;
  assign bus.mem_be     = be_q;
  // RAM data arrives in RESP; writes return zero.
  assign bus.resp_rd    = (state_q == S_RESP && !we_q) ? bus.mem_rd : '0;
  assign dbg_state      = state_q;

  // Next-state, latch and registered-output computation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wd_d         = wd_q;
    be_d         = be_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    resp_valid_d = 2'b00;
    case (state_q)
      S_ISSUE: begin
        state_d          = S_RESP;
        resp_valid_d[id_q] = 1'b1;
      end
      default: begin
        if (|grant) begin
          state_d      = S_ISSUE;
          last_grant_d = grant_id;
          id_d         = grant_id;
          mem_en_d     = 1'b1;
          if (grant_id == PORT_DBG) begin
            we_d   = bus.req_we[1];
            addr_d = bus.req_addr[ADDR_WIDTH +: ADDR_WIDTH];
            wd_d   = bus.req_wd[DATA_WIDTH +: DATA_WIDTH];
            be_d   = bus.req_be[BE_WIDTH +: BE_WIDTH];
          end else begin
            we_d   = bus.req_we[0];
            addr_d = bus.req_addr[0 +: ADDR_WIDTH];
            wd_d   = bus.req_wd[0 +: DATA_WIDTH];
            be_d   = bus.req_be[0 +: BE_WIDTH];
          end
          mem_we_d = we_d;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= PORT_DBG;
      id_q         <= PORT_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wd_q         <= '0;
      be_q         <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wd_q         <= wd_d;
      be_q         <= be_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous RAM model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  int n_cmp;
  int n_err;
  logic [DW-1:0] exp_q[$];

  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_q;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 32'hDEADBEEF;  // byte address 0x100
    rd_q = '0;
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < DW / 8; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_wd[b*8 +: 8];
      end else begin
        rd_q <= mem[bus.mem_addr[9:2]];
      end
    end
  end

  assign bus.mem_rd = rd_q;

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int port, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [3:0] be);
    bus.req_we[port]             = we;
    bus.req_addr[port*AW +: AW]  = addr;
    bus.req_wd[port*DW +: DW]    = wd;
    bus.req_be[port*4 +: 4]      = be;
    bus.req_valid[port]          = 1'b1;
  endtask

  task automatic drop_req(input int port);
    bus.req_valid[port] = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wd    = '0;
    bus.req_be    = '0;

    // 1. Reset with both ports requesting
    drive_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
    drive_req(1, 1'b0, 32'h200, 32'h0, 4'hF);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'(bus.req_ready), 64'(2'b00));
      check("rst_resp", 64'(bus.resp_valid), 64'(2'b00));
      check("rst_mem_en", 64'(bus.mem_en), 64'(1'b0));
    end
    check("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    #1;
    check("first_grant", 64'(bus.req_ready), 64'(2'b01));

    // 2. Single read on port 0
    @(posedge clk);
    #1;
    drop_req(0);
    drop_req(1);
    @(negedge clk);
    check("rd_mem_en", 64'(bus.mem_en), 64'(1'b1));
    check("rd_mem_we", 64'(bus.mem_we), 64'(1'b0));
    check("rd_mem_addr", 64'(bus.mem_addr), 64'h100);
    check("rd_issue_ready", 64'(bus.req_ready), 64'(2'b00));
    @(posedge clk);
    @(negedge clk);
    check("rd_resp", 64'(bus.resp_valid), 64'(2'b01));
    check("rd_data", 64'(bus.resp_rd), 64'hDEADBEEF);
    check("rd_resp_mem_en", 64'(bus.mem_en), 64'(1'b0));
    @(posedge clk);
    @(negedge clk);
    check("rd_idle", 64'(dbg_state), 64'(ST_IDLE));

    // 3. Port 1 write then read back
    drive_req(1, 1'b1, 32'h40, 32'h12345678, 4'hF);
    #1;
    check("wr_ready", 64'(bus.req_ready), 64'(2'b10));
    @(posedge clk);
    #1;
    drop_req(1);
    @(negedge clk);
    check("wr_mem_en", 64'(bus.mem_en), 64'(1'b1));
    check("wr_mem_we", 64'(bus.mem_we), 64'(1'b1));
    check("wr_mem_wd", 64'(bus.mem_wd), 64'h12345678);
    check("wr_mem_be", 64'(bus.mem_be), 64'hF);
    @(posedge clk);
    @(negedge clk);
    check("wr_resp", 64'(bus.resp_valid), 64'(2'b10));
    check("wr_resp_rd", 64'(bus.resp_rd), 64'h0);
    check("wr_we_one_cycle", 64'(bus.mem_we), 64'(1'b0));
    @(posedge clk);
    @(negedge clk);
    drive_req(1, 1'b0, 32'h40, 32'h0, 4'hF);
    #1;
    check("rb_ready", 64'(bus.req_ready), 64'(2'b10));
    @(posedge clk);
    #1;
    drop_req(1);
    @(negedge clk);
    check("rb_mem_en", 64'(bus.mem_en), 64'(1'b1));
    check("rb_mem_we", 64'(bus.mem_we), 64'(1'b0));
    @(posedge clk);
    @(negedge clk);
    check("rb_resp", 64'(bus.resp_valid), 64'(2'b10));
    check("rb_data", 64'(bus.resp_rd), 64'h12345678);
    @(posedge clk);
    @(negedge clk);

    // 4. Contention: both ports valid for 8 accesses, strict alternation
    drive_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
    drive_req(1, 1'b0, 32'h40, 32'h0, 4'hF);
    for (int k = 0; k < 8; k++) exp_q.push_back((k % 2 == 0) ? 32'hDEADBEEF : 32'h12345678);
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("cont_ready_%0d", k), 64'(bus.req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("cont_mem_en_%0d", k), 64'(bus.mem_en), 64'h1);
      check($sformatf("cont_addr_%0d", k), 64'(bus.mem_addr), (k % 2 == 0) ? 64'h100 : 64'h40);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("cont_gap_%0d", k), 64'(bus.mem_en), 64'h0);
      check($sformatf("cont_resp_%0d", k), 64'(bus.resp_valid), (k % 2 == 0) ? 64'h1 : 64'h2);
      check($sformatf("cont_data_%0d", k), 64'(bus.resp_rd), 64'(exp_q.pop_front()));
    end
    drop_req(0);
    drop_req(1);
    @(posedge clk);
    @(negedge clk);
    check("cont_idle", 64'(dbg_state), 64'(ST_IDLE));

    // 5. Port 1 request withdrawn during port 0's ISSUE
    drive_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
    #1;
    check("wd_ready0", 64'(bus.req_ready), 64'(2'b01));
    @(posedge clk);
    #1;
    drop_req(0);
    @(negedge clk);
    check("wd_issue", 64'(dbg_state), 64'(ST_ISSUE));
    drive_req(1, 1'b0, 32'h40, 32'h0, 4'hF);
    #1;
    check("wd_issue_ready", 64'(bus.req_ready), 64'(2'b00));
    #2;
    drop_req(1);
    @(posedge clk);
    @(negedge clk);
    check("wd_resp", 64'(bus.resp_valid), 64'(2'b01));
    check("wd_resp_ready", 64'(bus.req_ready), 64'(2'b00));
    check("wd_data", 64'(bus.resp_rd), 64'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    check("wd_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("wd_mem_en", 64'(bus.mem_en), 64'(1'b0));
    check("wd_no_resp", 64'(bus.resp_valid), 64'(2'b00));

    // 6. Reset during ISSUE of a port 0 read
    drive_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    drop_req(0);
    @(negedge clk);
    check("mr_issue", 64'(bus.mem_en), 64'(1'b1));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mr_no_resp", 64'(bus.resp_valid), 64'(2'b00));
    check("mr_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("mr_mem_en", 64'(bus.mem_en), 64'(1'b0));
    check("mr_mem_addr", 64'(bus.mem_addr), 64'h0);
    drive_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
    drive_req(1, 1'b0, 32'h40, 32'h0, 4'hF);
    #1;
    check("mr_ready_in_rst", 64'(bus.req_ready), 64'(2'b00));
    rst = 1'b0;
    #1;
    check("mr_grant0", 64'(bus.req_ready), 64'(2'b01));
    @(posedge clk);
    #1;
    drop_req(0);
    drop_req(1);
    @(negedge clk);
    check("mr_addr", 64'(bus.mem_addr), 64'h100);
    @(posedge clk);
    @(negedge clk);
    check("mr_resp", 64'(bus.resp_valid), 64'(2'b01));
    check("mr_data", 64'(bus.resp_rd), 64'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port synchronous data memory between two requesters: port 0 (CPU load/store path) and port 1 (debug/loader master).
- Sits between the cpu top level and the data RAM.
- Each requester uses a valid/ready request channel and a one-cycle response pulse.
- Tie-breaking is round-robin. One access is outstanding at a time. Memory read latency is 1 cycle.

Parameters:
- DATA_WIDTH, 32, memory word width in bits.
- ADDR_WIDTH, 32, byte address width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived; do not override).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit i belongs to port i.
- req_ready  out  2  per-port request accept.
- req_we  in  2  per-port write flag (1 = store).
- req_addr  in  2*ADDR_WIDTH  per-port address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wd  in  2*DATA_WIDTH  per-port write data, packed the same way.
- req_be  in  2*BE_WIDTH  per-port byte enables, packed the same way.
- resp_valid  out  2  one-cycle completion pulse per port; fires for reads and writes.
- resp_rd  out  DATA_WIDTH  read data; valid while a resp_valid bit is set.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wd  out  DATA_WIDTH  memory write data.
- mem_be  out  BE_WIDTH  memory byte enables.
- mem_rd  in  DATA_WIDTH  memory read data, valid the cycle after the mem_en cycle.

Behaviour:

States:
- IDLE: no access in flight.
- ISSUE: memory access is driven.
- RESP: memory data is returning.

Reset (rst=1 at a clock edge):
- state=IDLE, last_grant=1 (so port 0 wins the first tie).
- All latched request fields cleared; resp_valid=0, resp_rd=0.
- mem_en=0, mem_we=0, mem_addr=0, mem_wd=0, mem_be=0.
- An in-flight access is abandoned with no response pulse. A write already strobed to memory has still happened.

Arbitration (combinational; evaluated only in IDLE or RESP):
- If exactly one valid bit is set, that port wins.
- If both are set, the winner is the port that is not last_grant.
- If neither is set, there is no winner.
- req_ready[winner]=1; every other req_ready bit is 0.
- req_ready is 0 in every bit during ISSUE.
- req_ready is combinational from req_valid and state. req_valid must not depend on req_ready.

Accept:
- A transfer occurs on a cycle with req_valid[i] && req_ready[i].
- On that edge: latch we/addr/wd/be and the port id, set last_grant=id, go to ISSUE.

ISSUE (exactly 1 cycle):
- mem_en=1 and mem_we=latched we.
- mem_addr/mem_wd/mem_be = latched values.
- Next state is RESP.

RESP (1 cycle):
- resp_valid[id]=1; the other resp_valid bit is 0.
- resp_rd=mem_rd for a read, 0 for a write.
- mem_en=0.
- Arbitration is live: if a winner is accepted, go to ISSUE; otherwise go to IDLE.
- Back-to-back sustained throughput is one access per 2 cycles.

Latency:
- Accept edge at cycle N: mem_en high in cycle N+1, resp_valid high in cycle N+2.

Memory outputs outside ISSUE:
- mem_en=0 and mem_we=0.
- mem_addr/mem_wd/mem_be hold their last latched values. They are never X after reset.

Requester rules:
- A requester must hold its request fields stable while req_valid=1 and req_ready=0.
- It may deassert req_valid before it is accepted. This is not an error; nothing is latched.

Fairness:
- With both ports continuously valid, grants strictly alternate 0,1,0,1,...
- Neither port waits more than one foreign access.

Boundary cases:
- A port may re-request on the same cycle it receives its own response. It is arbitrated like any other request.
- Address and data are passed through unmodified. Alignment is the requester's responsibility.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_RESP=2'd2) and a PORT_CPU=0 / PORT_DBG=1 id constant.
- One natural sub-module: rr_arbiter2. It is a 2-input round-robin picker with inputs valid[1:0], last_grant, enable, and outputs grant[1:0], grant_id.
- The FSM and latches stay in dmem_arbiter.

Test Plan:
1. Reset:
   - Stimulus: assert rst for 2 cycles with req_valid=2'b11.
   - Response: req_ready=0, resp_valid=0, mem_en=0 throughout reset.
   - After release: first grant goes to port 0.
2. Single read:
   - Stimulus: port 0 reads addr 0x100; memory model returns 0xDEADBEEF.
   - Response: mem_en=1 at N+1 with mem_addr=0x100 and mem_we=0.
   - Then resp_valid=2'b01 and resp_rd=0xDEADBEEF at N+2; state returns to IDLE.
3. Write then read-back:
   - Stimulus: port 1 writes 0x12345678 to addr 0x40 with be=4'hF, then reads 0x40.
   - Response: mem_we=1 for exactly 1 cycle; write response resp_valid=2'b10 with resp_rd=0.
   - Read returns 0x12345678.
4. Contention:
   - Stimulus: both ports valid continuously for 8 accesses.
   - Response: grant order is 0,1,0,1,0,1,0,1; one mem_en every 2 cycles.
   - Each response pulse lands on the correct port.
5. Withdrawn request:
   - Stimulus: port 1 is valid during port 0's ISSUE cycle, then drops valid before RESP.
   - Response: no access for port 1; state returns to IDLE; mem_en stays 0.
6. Reset mid-operation:
   - Stimulus: assert rst during ISSUE of a read.
   - Response: no resp_valid pulse for that read; state returns to IDLE; next grant goes to port 0.
